sram_port0_arbiter: RTL and testbench
=====================================

# sram_port0_arbiter

Controller that owns the RW port (port 0) of the 32x512 1RW1R SRAM macro and shares it between NREQ requesters. It zero-fills the array after reset, then grants one request per cycle with round-robin arbitration. It drives the macro pins from registers and returns read data with a fixed latency. It sits between the user-project logic (Wishbone slave, core fetch/load units) and the macro; port 1 of the macro is not touched by this block.

## Interface
- NREQ, 2, number of requesters (2..4)
- ADDR_WIDTH, 9, SRAM word address width
- DATA_WIDTH, 32, SRAM word width
- NUM_WMASKS, 4, byte write-enable count
- CLEAR_ON_RESET, 1, 1 = zero-fill all 512 words after reset; 0 = skip the fill

Ports:
- wb_clk_i  in  1  the single clock; also drives the macro clk0
- wb_rst_i  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  grant; at most one bit high per cycle
- req_we  in  NREQ  1 = write, 0 = read
- req_wmask  in  NREQ*NUM_WMASKS  byte enables, requester i at [i*4 +: 4]
- req_addr  in  NREQ*ADDR_WIDTH  word address, packed the same way
- req_wdata  in  NREQ*DATA_WIDTH  write data, packed the same way
- rsp_valid  out  NREQ  one-cycle completion pulse for the owning requester
- rsp_rdata  out  DATA_WIDTH  read data, shared, valid while a read's rsp_valid is high
- init_done  out  1  high once the zero-fill has completed
- sram_csb0, sram_web0  out  1 each  macro chip select and write enable, both active-low
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_dout0  in  DATA_WIDTH  macro read data

## Operation
- FSM states: INIT and RUN. Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
- INIT behaviour:
  - A 9-bit counter steps 0..511, one write per cycle: csb0=0, web0=0, wmask=4'hF, addr=count, din=0.
  - After count 511 the FSM moves to RUN.
  - req_ready is held 0 throughout INIT.
- RUN, arbitration:
  - rr_ptr (reset 0) marks the highest-priority requester.
  - The grant goes to the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready equals the grant. It is combinational from req_valid and rr_ptr, with no combinational path from the ready output back to the valid input.
  - After any grant, rr_ptr becomes granted index + 1, mod NREQ.
- RUN, transaction issue:
  - An accepted request loads the pin registers: csb0=0, web0=~we, plus wmask, addr and wdata.
  - A cycle with no accept loads csb0=1, web0=1 and holds the other pins at their last values.
- Response tracking:
  - A 3-deep shift of {valid, id, is_read} follows each accepted transaction.
  - Reads capture sram_dout0 into rsp_rdata. Writes pulse rsp_valid but leave rsp_rdata unchanged.
  - Responses cannot be back-pressured; requesters must accept rsp_valid whenever it arrives.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, rr_ptr=0, INIT counter=0.

## Timing
- Issue: request accepted in cycle C, macro pins driven in C+1, macro latches them at the end of C+1.
- Read data: the macro produces data on the falling edge inside C+2; the block registers it at the end of C+2.
- Response: rsp_valid (and rsp_rdata for reads) is high in C+3. Fixed latency is 3 cycles for reads and writes.
- Throughput: one transaction per cycle; back-to-back grants to the same requester are allowed when only that requester is valid.
- Read-after-write to the same address, accepted in consecutive cycles: the read returns the new data, so no hazard logic is needed.
- INIT duration: 512 cycles after the reset release edge. init_done rises in the first RUN cycle, and a grant is possible in that same cycle.
- With CLEAR_ON_RESET=0, init_done is 1 in the first cycle after reset.
- Reset asserted mid-INIT: the fill restarts at address 0.
- Reset asserted in RUN: in-flight responses are dropped (no rsp_valid), and csb0 returns to 1 on the next edge.
- Simultaneous valids: exactly one grant per cycle; the others keep req_valid high and wait.

## Structure
- Shared package sram_ctrl_pkg holds:
  - SRAM_ADDR_WIDTH=9, SRAM_DATA_WIDTH=32, SRAM_NUM_WMASKS=4, SRAM_DEPTH=512
  - FSM state typedef {ST_INIT, ST_RUN}
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Inputs req and ptr; outputs a one-hot grant and the next pointer.
  - Purely combinational; rr_ptr is stored in the parent.
- The macro is instantiated outside this block and connected to the sram_* ports. clk0 = wb_clk_i.

## Test plan
- Reset release with CLEAR_ON_RESET=1:
  - INIT drives 512 writes, addr 0..511, din 0, wmask F, with req_ready 0 throughout.
  - init_done rises in cycle 512.
  - A subsequent read of addr 0x1FF returns 0.
- Write then read back:
  - Req0 writes addr 0x005 data 0xDEADBEEF, wmask F; then reads 0x005.
  - Each rsp_valid arrives 3 cycles after its accept; the read returns 0xDEADBEEF.
- Partial write:
  - Write 0x11223344 to addr 0x010, then write 0xAABBCCDD with wmask 4'b0101.
  - Read returns 0x11BB33DD.
- Contention:
  - Req0 and req1 both hold valid for 4 cycles with reads of distinct addresses.
  - Grants alternate 0,1,0,1; each rsp_valid goes to the correct requester with the correct data.
- Back-to-back read-after-write:
  - Write 0x0CAFE000 to 0x1A0, and the read of 0x1A0 is accepted in the very next cycle.
  - The read returns 0x0CAFE000.
- Reset mid-stream:
  - Assert wb_rst_i one cycle after a read is accepted.
  - No rsp_valid appears, csb0=1 on the next edge, and INIT restarts at addr 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: SRAM macro geometry, controller FSM states and the
// response tag carried alongside each issued port-0 transaction.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_WIDTH = 9;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_NUM_WMASKS = 4;
  localparam int SRAM_DEPTH      = 512;

  // Requester id width; covers up to 4 requesters.
  localparam int RSP_ID_W = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } ctrl_state_t;

  typedef struct packed {
    logic                vld;
    logic [RSP_ID_W-1:0] id;
    logic                rd;
  } rsp_tag_t;

endpackage

// File: rtl/sram_port0_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
// Ports: i_req (requests), i_ptr (top priority), o_grant (one-hot),
// o_next_ptr (granted index + 1 mod NREQ, else i_ptr).
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_next_ptr
);

  logic w_found;

  // Walk offsets from the pointer; the first live request wins.
  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && i_req[j] &&
            (j == (int'(i_ptr) + k) % NREQ)) begin
          w_found    = 1'b1;
          o_grant[j] = 1'b1;
          o_next_ptr = PW'((j + 1) % NREQ);
        end
      end
    end
  end

endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: owns SRAM port 0; zero-fills after reset, then
// grants one request per cycle round-robin with 3-cycle responses.
// Ports: wb_clk_i/wb_rst_i; req_* requester side (packed per index);
// rsp_valid/rsp_rdata completions; init_done; sram_* macro port 0 pins.
module sram_port0_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int ADDR_WIDTH     = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS     = SRAM_NUM_WMASKS,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*NUM_WMASKS-1:0] req_wmask,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       init_done,
  output logic                       sram_csb0,
  output logic                       sram_web0,
  output logic [NUM_WMASKS-1:0]      sram_wmask0,
  output logic [ADDR_WIDTH-1:0]      sram_addr0,
  output logic [DATA_WIDTH-1:0]      sram_din0,
  input  logic [DATA_WIDTH-1:0]      sram_dout0
);

  localparam int PW = $clog2(NREQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(SRAM_DEPTH - 1);

  ctrl_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [PW-1:0]         r_rr_ptr;
  logic                  r_init_done;
  rsp_tag_t              r_s0;
  rsp_tag_t              r_s1;

  logic [NREQ-1:0]       w_grant;
  logic [NREQ-1:0]       w_ready;
  logic [PW-1:0]         w_next_ptr;
  logic                  w_accept;
  logic [RSP_ID_W-1:0]   w_id;
  logic                  w_we;
  logic [NUM_WMASKS-1:0] w_wmask;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NREQ-1:0]       w_rsp_hot;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_grant),
    .o_next_ptr(w_next_ptr)
  );

  // Grants only once the fill is over; never while reset is held.
  assign w_ready   = w_grant & {NREQ{r_init_done & ~wb_rst_i}};
  assign w_accept  = |w_ready;
  assign req_ready = w_ready;
  assign init_done = r_init_done;

  always_comb begin
    w_id    = '0;
    w_we    = 1'b0;
    w_wmask = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) begin
        w_id    = RSP_ID_W'(j);
        w_we    = req_we[j];
        w_wmask = req_wmask[j*NUM_WMASKS +: NUM_WMASKS];
        w_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_rsp_hot = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_rsp_hot[j] = r_s1.vld && (r_s1.id == RSP_ID_W'(j));
    end
  end

  // Control FSM and macro pin registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_init_done <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          sram_csb0   <= 1'b0;
          sram_web0   <= 1'b0;
          sram_wmask0 <= '1;
          sram_addr0  <= r_cnt;
          sram_din0   <= '0;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
          if (w_accept) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~w_we;
            sram_wmask0 <= w_wmask;
            sram_addr0  <= w_addr;
            sram_din0   <= w_wdata;
            r_rr_ptr    <= w_next_ptr;
          end else begin
            // Idle: deselect, keep data/address pins quiet.
            sram_csb0 <= 1'b1;
            sram_web0 <= 1'b1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Response tracking: tag rides with the transaction; read data is
  // captured in the same edge that launches rsp_valid.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s0      <= '0;
      r_s1      <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      r_s0      <= '{vld: w_accept, id: w_id, rd: ~w_we};
      r_s1      <= r_s0;
      rsp_valid <= w_rsp_hot;
      if (r_s1.vld && r_s1.rd) begin
        rsp_rdata <= sram_dout0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb_sram_port0_arbiter: randomized + directed bench with a behavioural
// SRAM macro and a transaction-level reference model.
module tb_sram_port0_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int NW   = 4;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*NW-1:0] req_wmask;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              init_done;
  logic              sram_csb0;
  logic              sram_web0;
  logic [NW-1:0]     sram_wmask0;
  logic [AW-1:0]     sram_addr0;
  logic [DW-1:0]     sram_din0;
  logic [DW-1:0]     sram_dout0;

  always #5 wb_clk_i = ~wb_clk_i;

  sram_port0_arbiter #(
    .NREQ          (NREQ),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .NUM_WMASKS    (NW),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  // Behavioural 1RW macro port: latch on rise, read data on next fall.
  logic [DW-1:0] mem [512];
  logic          mac_rd;
  logic [AW-1:0] mac_addr;

  initial begin
    mac_rd   = 1'b0;
    mac_addr = '0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom();
    forever begin
      @(posedge wb_clk_i);
      mac_rd = 1'b0;
      if (!sram_csb0) begin
        if (!sram_web0) begin
          for (int b = 0; b < NW; b++)
            if (sram_wmask0[b])
              mem[sram_addr0][b*8 +: 8] = sram_din0[b*8 +: 8];
        end else begin
          mac_rd   = 1'b1;
          mac_addr = sram_addr0;
        end
      end
    end
  end

  initial begin
    sram_dout0 = '0;
    forever begin
      @(negedge wb_clk_i);
      if (mac_rd) sram_dout0 = mem[mac_addr];
    end
  end

  // Reference model state.
  typedef struct {
    int          due;
    int          id;
    bit          rd;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] ref_mem [512];
  exp_t          q[$];
  int            m_ptr;
  int            cyc;
  logic [DW-1:0] m_rdata;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] obs_ready;
  logic [7:0]    seq;
  int            n_chk;
  int            n_err;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr   = 0;
    m_rdata = '0;
    pend    = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
  endtask

  // One RUN cycle: check grant and responses mid-cycle, then advance.
  task automatic step();
    int            g;
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ers;
    logic [AW-1:0] a;
    exp_t          e;
    @(negedge wb_clk_i);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[j]) g = j;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    obs_ready = req_ready;
    chk("req_ready", req_ready, eg);
    ers = '0;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ers[e.id] = 1'b1;
      if (e.rd) m_rdata = e.data;
    end
    chk("rsp_valid", rsp_valid, ers);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    if (g >= 0) begin
      e.due  = cyc + 3;
      e.id   = g;
      e.rd   = !req_we[g];
      e.data = '0;
      a = req_addr[g*AW +: AW];
      if (req_we[g]) begin
        for (int b = 0; b < NW; b++)
          if (req_wmask[g*NW + b])
            ref_mem[a][b*8 +: 8] = req_wdata[g*DW + b*8 +: 8];
      end else begin
        e.data = ref_mem[a];
      end
      q.push_back(e);
      m_ptr   = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end
    @(posedge wb_clk_i);
    #1;
    cyc++;
  endtask

  task automatic issue(input int id, input bit we, input logic [3:0] m,
                       input logic [8:0] a, input logic [31:0] d);
    req_valid               = '0;
    req_valid[id]           = 1'b1;
    req_we[id]              = we;
    req_wmask[id*NW +: NW]  = m;
    req_addr[id*AW +: AW]   = a;
    req_wdata[id*DW +: DW]  = d;
    step();
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  // Called in the cycle after the last reset edge, reset now low.
  task automatic init_check();
    req_valid = NREQ'($urandom());
    req_we    = NREQ'($urandom());
    #1;
    chk("init_ready", req_ready, 0);
    for (int n = 1; n <= 512; n++) begin
      @(posedge wb_clk_i);
      #1;
      chk("init_pins",
          {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
          {1'b0, 1'b0, 4'hF, AW'(n - 1), 32'h0});
      chk("init_done", init_done, n == 512);
      chk("init_rsp", rsp_valid, 0);
      if (n < 512) begin
        req_valid = NREQ'($urandom());
        #1;
        chk("init_ready", req_ready, 0);
      end else begin
        req_valid = '0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_err     = 0;
    cyc       = 0;
    seq       = '0;
    obs_ready = '0;
    wb_rst_i  = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_wmask = '0;
    req_addr  = '0;
    req_wdata = '0;
    model_reset();

    repeat (3) begin
      @(posedge wb_clk_i);
      #1;
      req_valid = NREQ'($urandom());
      req_we    = NREQ'($urandom());
    end
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata, init_done}, 0);
    chk("rst_pins",
        {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
        {1'b1, 1'b1, 45'h0});
    wb_rst_i = 1'b0;
    init_check();

    issue(0, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF);
    issue(0, 1'b0, 4'hF, 9'h005, 32'h0);
    idle(4);
    chk("wr_rd_005", rsp_rdata, 32'hDEADBEEF);

    issue(1, 1'b0, 4'hF, 9'h1FF, 32'h0);
    idle(4);
    chk("rd_1ff_fill", rsp_rdata, 32'h0);

    issue(0, 1'b1, 4'hF, 9'h010, 32'h11223344);
    issue(0, 1'b1, 4'b0101, 9'h010, 32'hAABBCCDD);
    issue(0, 1'b0, 4'hF, 9'h010, 32'h0);
    idle(4);
    chk("partial_wr", rsp_rdata, 32'h11BB33DD);

    issue(1, 1'b1, 4'hF, 9'h1A0, 32'h0CAFE000);
    issue(1, 1'b0, 4'hF, 9'h1A0, 32'h0);
    idle(4);
    chk("raw_1a0", rsp_rdata, 32'h0CAFE000);

    req_we    = '0;
    req_addr  = {9'h010, 9'h005};
    req_valid = '1;
    for (int i = 0; i < 4; i++) begin
      step();
      seq = {seq[5:0], obs_ready};
    end
    idle(4);
    chk("contention_seq", seq, 8'b01_10_01_10);
    chk("contention_data", rsp_rdata, 32'h11BB33DD);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i]               = 1'b1;
          req_we[i]             = 1'($urandom_range(0, 1));
          req_wmask[i*NW +: NW] = NW'($urandom());
          req_addr[i*AW +: AW]  = AW'($urandom_range(0, 31));
          req_wdata[i*DW +: DW] = $urandom();
        end
      end
      req_valid = pend;
      step();
    end
    idle(4);

    issue(0, 1'b0, 4'hF, 9'h005, 32'h0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("rst_mid_rsp", rsp_valid, 0);
    @(posedge wb_clk_i);
    #1;
    chk("rst_mid_csb", sram_csb0, 1'b1);
    chk("rst_mid_rsp2", rsp_valid, 0);
    chk("rst_mid_rdata", rsp_rdata, 0);
    wb_rst_i = 1'b0;
    model_reset();
    init_check();

    issue(0, 1'b1, 4'hF, 9'h006, 32'h12345678);
    issue(0, 1'b0, 4'hF, 9'h006, 32'h0);
    issue(1, 1'b0, 4'hF, 9'h005, 32'h0);
    idle(4);
    chk("refill_005", rsp_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
